// File: rtl/alu_seq_pkg.sv
// Package: alu_seq_pkg
// Shared definitions for the nibble-serial ALU sequencer and its 4-bit slice.
//   - op encodings (op[2] is the B-invert / carry-in-one bit)
//   - sequencer state enum
//   - NIBBLE_W, the width of one slice pass
package alu_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_alu_slice.sv
// Module: nibble_alu_slice
// Combinational 4-bit ALU slice (AND / OR / add / less-pass-through).
// Ports:
//   a_i, b_i     4-bit operands
//   op_i         op[2] inverts B; op[1:0] selects AND, OR, SUM, LESS
//   cin_i        carry in
//   less_i       value placed in bit 0 when op[1:0] selects LESS
//   result_o     4-bit result
//   cout_o       carry out of bit 3
//   set_o        bit 3 of the sum (sign of a-b for SLT on the MSB slice)
//   overflow_o   signed overflow of the 4-bit add
//   zero_o       result_o == 0
module nibble_alu_slice
  import alu_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic [2:0]          op_i,
  input  logic                cin_i,
  input  logic                less_i,
  output logic [NIBBLE_W-1:0] result_o,
  output logic                cout_o,
  output logic                set_o,
  output logic                overflow_o,
  output logic                zero_o
);

  logic [NIBBLE_W-1:0] b_eff;
  logic [NIBBLE_W:0]   sum;

  assign b_eff = op_i[2] ? ~b_i : b_i;
  // The adder runs for every op so cout/overflow/set are always defined.
  assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {{NIBBLE_W{1'b0}}, cin_i};

  always_comb begin
    result_o = '0;
    case (op_i[1:0])
      OP_AND[1:0]: result_o = a_i & b_eff;
      OP_OR[1:0]:  result_o = a_i | b_eff;
      OP_ADD[1:0]: result_o = sum[NIBBLE_W-1:0];
      default:     result_o = {{(NIBBLE_W-1){1'b0}}, less_i};
    endcase
  end

  assign cout_o     = sum[NIBBLE_W];
  assign set_o      = sum[NIBBLE_W-1];
  assign overflow_o = (a_i[NIBBLE_W-1] == b_eff[NIBBLE_W-1]) &&
                      (sum[NIBBLE_W-1] != a_i[NIBBLE_W-1]);
  assign zero_o     = (result_o == '0);

endmodule

// File: rtl/nibble_serial_alu_seq.sv
// Module: nibble_serial_alu_seq
// Performs a WIDTH-bit ALU operation by running one 4-bit slice per cycle,
// least-significant nibble first, chaining carry through a register.
// WIDTH must be a multiple of 4 and at least 8.
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1; a, b and op are captured on that edge. start while ready=0 is
// dropped, never queued. done is a one-cycle pulse during which result and
// flags are valid; they then hold until the next accepted start.
//
// Configuration macro ALU_SEQ_BACK2BACK_EN: when defined, ready is also high
// in DONE so a new operation can start on the edge that leaves DONE.
//
// Ports:
//   clk, reset      clock (rising edge), synchronous active-high reset
//   start, ready    request / accept handshake
//   a, b, op        operands and op code (op[2] = B invert)
//   done            one-cycle completion pulse
//   result          WIDTH-bit result
//   cout, overflow  carry and signed overflow of the MSB nibble
//   set             MSB sum bit of the final pass
//   zero            result == 0
//   dbg_state_o     current FSM state, for observation only
module nibble_serial_alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             set,
  output logic             zero,
  output logic [1:0]       dbg_state_o
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, set_q, set_d, zero_q, zero_d;
  logic             accept;

  logic [NIBBLE_W-1:0] s_a, s_b, s_res;
  logic                s_cout, s_set, s_ovf, s_zero;

  assign s_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign s_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  nibble_alu_slice u_slice (
    .a_i        (s_a),
    .b_i        (s_b),
    .op_i       (op_q),
    .cin_i      (carry_q),
    .less_i     (1'b0),
    .result_o   (s_res),
    .cout_o     (s_cout),
    .set_o      (s_set),
    .overflow_o (s_ovf),
    .zero_o     (s_zero)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    set_d    = set_q;
    zero_d   = zero_q;
    ready    = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;

    case (state_q)
      IDLE: begin
        ready  = 1'b1;
        accept = start;
      end
      RUN: begin
        result_d[idx_q*NIBBLE_W +: NIBBLE_W] = s_res;
        carry_d = s_cout;
        zacc_d  = zacc_q & s_zero;
        if (idx_q == LAST_IDX) begin
          cout_d  = s_cout;
          ovf_d   = s_ovf;
          set_d   = s_set;
          // SLT replaces the whole result with the sign of a-b, computed
          // only on this final pass.
          if (op_q == OP_SLT) begin
            result_d = WIDTH'(s_set);
            zero_d   = ~s_set;
          end else begin
            zero_d   = zacc_q & s_zero;
          end
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
`ifdef ALU_SEQ_BACK2BACK_EN
        ready   = 1'b1;
        accept  = start;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Capture is shared by IDLE and (optionally) DONE; result and flags are
    // left alone so the finishing operation's outputs stay valid this cycle.
    if (accept) begin
      a_d     = a;
      b_d     = b;
      op_d    = op;
      idx_d   = '0;
      carry_d = op[2];
      zacc_d  = 1'b1;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      set_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      set_q    <= set_d;
      zero_q   <= zero_d;
    end
  end

  assign result      = result_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;
  assign set         = set_q;
  assign zero        = zero_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nibble_serial_alu_seq.sv
// Testbench for nibble_serial_alu_seq (WIDTH=16).
module tb_nibble_serial_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   op = '0;
  logic         ready, done, cout, overflow, set, zero;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  nibble_serial_alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ready       (ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .done        (done),
    .result      (result),
    .cout        (cout),
    .overflow    (overflow),
    .set         (set),
    .zero        (zero),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         st;
    logic         z;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Whole-word reference: the nibble chain must equal one WIDTH-bit add.
  function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    vec_t         v;
    logic [W-1:0] yy;
    logic [W:0]   full;
    yy     = o[2] ? ~y : y;
    full   = {1'b0, x} + {1'b0, yy} + (W+1)'(o[2]);
    v.op   = o;
    v.a    = x;
    v.b    = y;
    v.co   = full[W];
    v.st   = full[W-1];
    v.ov   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    case (o[1:0])
      2'b00:   v.res = x & yy;
      2'b01:   v.res = x | yy;
      2'b10:   v.res = full[W-1:0];
      default: v.res = '0;
    endcase
    if (o == 3'b111) v.res = W'(v.st);
    v.z = (v.res == '0);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", {15'b0, ready}, 16'd1);
  endtask

  // Issues one op and waits for done. lat counts negedges after the accept
  // edge (1 = cycle right after accept). poke pulses start mid-run.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit poke, output vec_t got, output int lat);
    int c;
    wait_ready();
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    c   = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
      if (poke && c == 2) begin start = 1'b1; a = ~x; b = x; op = 3'b001; end
      if (poke && c == 3) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    got.op  = o; got.a = x; got.b = y;
    got.res = result; got.co = cout; got.ov = overflow; got.st = set; got.z = zero;
  endtask

  task automatic check_result(input string tag, input vec_t got, input vec_t exp, input int lat);
    chk({tag, "_latency"}, W'(lat), W'(5));
    chk({tag, "_result"},  got.res, exp.res);
    chk({tag, "_cout"},    W'(got.co), W'(exp.co));
    chk({tag, "_ovf"},     W'(got.ov), W'(exp.ov));
    chk({tag, "_set"},     W'(got.st), W'(exp.st));
    chk({tag, "_zero"},    W'(got.z),  W'(exp.z));
    @(negedge clk);
    chk({tag, "_done_width"}, W'(done), W'(0));
    chk({tag, "_hold"},    result, exp.res);
  endtask

  // ---------------- test ----------------
  vec_t vecs[6];
  vec_t got, exp;
  int   lat;

  initial begin
    // {op, a, b, result, cout, overflow, set, zero}
    vecs[0] = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{OP_SUB, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{OP_SLT, 16'h0003, 16'h0005, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{OP_SLT, 16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_OR,  16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready",  W'(ready), W'(1));
    chk("rst_done",   W'(done), W'(0));
    chk("rst_result", result, '0);
    chk("rst_flags",  W'({cout, overflow, set, zero}), W'(0));
    chk("rst_state",  W'(dbg_state), W'(IDLE));

    // Directed table; the AND entry also pulses start mid-run.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i == 4), got, lat);
      check_result($sformatf("vec%0d", i), got, vecs[i], lat);
    end

    // Reset during an in-flight ADD: no done pulse, clean return to idle.
    begin
      bit seen_done;
      wait_ready();
      op = OP_ADD; a = 16'h00FF; b = 16'h0001; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_ready",  W'(ready), W'(1));
      chk("abort_result", result, '0);
      chk("abort_state",  W'(dbg_state), W'(IDLE));
      seen_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (done) seen_done = 1'b1;
        @(negedge clk);
      end
      chk("abort_no_done", W'(seen_done), W'(0));
      run_op(OP_ADD, 16'h00FF, 16'h0001, 1'b0, got, lat);
      check_result("after_abort", got, model(OP_ADD, 16'h00FF, 16'h0001), lat);
    end

    // Back-to-back: start held high, second operands shown during DONE.
    begin
      int c, first, second;
      bit dropped;
      wait_ready();
      op = OP_ADD; a = 16'd1; b = 16'd1; start = 1'b1;
      first = -1; second = -1; dropped = 1'b0;
      for (c = 0; c < 40 && second < 0; c++) begin
        @(negedge clk);
        if (first >= 0 && !dropped && !ready) begin start = 1'b0; dropped = 1'b1; end
        if (done) begin
          if (first < 0) begin
            first = c;
            chk("b2b_first_result", result, 16'h0002);
            a = 16'd2; b = 16'd2;
          end else begin
            second = c;
            chk("b2b_second_result", result, 16'h0004);
          end
        end
      end
      start = 1'b0;
`ifdef ALU_SEQ_BACK2BACK_EN
      chk("b2b_interval", W'(second - first), W'(5));
`else
      chk("b2b_interval", W'(second - first), W'(6));
`endif
    end

    // Randomized ops, including unlisted codes, against the model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   o;
      logic [W-1:0] x, y;
      o = 3'($urandom_range(0, 7));
      x = W'($urandom);
      y = ($urandom_range(0, 4) == 0) ? x : W'($urandom);
      exp = model(o, x, y);
      exp_q.push_back(exp.res);
      run_op(o, x, y, 1'b0, got, lat);
      chk($sformatf("rnd%0d_result", i), got.res, exp_q.pop_front());
      chk($sformatf("rnd%0d_latency", i), W'(lat), W'(5));
      chk($sformatf("rnd%0d_flags", i), W'({got.co, got.ov, got.st, got.z}),
          W'({exp.co, exp.ov, exp.st, exp.z}));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
